// File: rtl/scan_chain_node_pkg.sv
// Shared scan-chain constants and types used by the chain nodes and the scan controller.
// The edge event type lets a synchronized input report one of none/rise/fall per clk cycle.
package scan_chain_node_pkg;

  localparam int NUM_IOS_DEF = 8;
  localparam int SYNC_DEPTH  = 2;
  localparam int SYNC_MSB    = SYNC_DEPTH - 1;

  typedef enum logic [1:0] {
    EDGE_NONE = 2'd0,
    EDGE_RISE = 2'd1,
    EDGE_FALL = 2'd2
  } edge_e;

endpackage

// File: rtl/scan_chain_node_if.sv
// Four-wire scan link between neighbouring nodes: clock, serial data, select, latch enable.
// The upstream side drives (master); the downstream node receives (slave).
interface scan_chain_node_if;

  logic scan_clk;
  logic scan_data;
  logic scan_select;
  logic scan_latch_en;

  modport master (output scan_clk, output scan_data, output scan_select, output scan_latch_en);
  modport slave  (input  scan_clk, input  scan_data, input  scan_select, input  scan_latch_en);

endinterface

// File: rtl/scan_chain_node_sync_edge.sv
// Synchronizes one asynchronous level into clk and flags its rising/falling transitions.
// Edge event appears SYNC_DEPTH cycles after the input moves; dly is one cycle later still.
module sync_edge
  import scan_chain_node_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  din,
  output edge_e ev,
  output logic  dly
);

  logic [SYNC_DEPTH-1:0] sync_q, sync_d;
  logic                  dly_q, dly_d;

  always_comb begin
    sync_d = {sync_q[SYNC_DEPTH-2:0], din};
    dly_d  = sync_q[SYNC_MSB];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      dly_q  <= 1'b0;
    end else begin
      sync_q <= sync_d;
      dly_q  <= dly_d;
    end
  end

  // dly_q doubles as the edge history: comparing it with the synced level yields the edge
  always_comb begin
    ev = EDGE_NONE;
    if (sync_q[SYNC_MSB] && !dly_q) begin
      ev = EDGE_RISE;
    end else if (!sync_q[SYNC_MSB] && dly_q) begin
      ev = EDGE_FALL;
    end
  end

  assign dly = dly_q;

endmodule

// File: rtl/scan_chain_node.sv
// One node of a daisy-chained scan path: shifts/captures on scan clock rises, drives data out on falls.
// Forwarded clock/select/latch lag their inputs by exactly 3 clk cycles.
module scan_chain_node
  import scan_chain_node_pkg::*;
#(
  parameter int NUM_IOS = NUM_IOS_DEF
)
(
  input  logic                 clk,
  input  logic                 reset,
  scan_chain_node_if.slave     up,
  scan_chain_node_if.master    dn,
  output logic [NUM_IOS-1:0]   module_data_in,
  input  logic [NUM_IOS-1:0]   module_data_out
);

  localparam int PL = NUM_IOS - 1;

  edge_e                 clk_ev, latch_ev;
  logic                  clk_dly, latch_dly;
  logic [SYNC_DEPTH-1:0] data_sync_q, data_sync_d;
  logic [SYNC_DEPTH-1:0] sel_sync_q, sel_sync_d;
  logic                  sel_dly_q, sel_dly_d;
  logic [PL:0]           shift_q, shift_d;
  logic [PL:0]           mdi_q, mdi_d;
  logic                  dout_q, dout_d;

  sync_edge u_clk_sync (
    .clk   (clk),
    .reset (reset),
    .din   (up.scan_clk),
    .ev    (clk_ev),
    .dly   (clk_dly)
  );

  sync_edge u_latch_sync (
    .clk   (clk),
    .reset (reset),
    .din   (up.scan_latch_en),
    .ev    (latch_ev),
    .dly   (latch_dly)
  );

  always_comb begin
    data_sync_d = {data_sync_q[SYNC_DEPTH-2:0], up.scan_data};
    sel_sync_d  = {sel_sync_q[SYNC_DEPTH-2:0], up.scan_select};
    sel_dly_d   = sel_sync_q[SYNC_MSB];
    shift_d     = shift_q;
    dout_d      = dout_q;
    mdi_d       = mdi_q;

    if (clk_ev == EDGE_RISE) begin
      if (sel_sync_q[SYNC_MSB]) begin
        shift_d = module_data_out;
      end else begin
        shift_d = {shift_q[PL-1:0], data_sync_q[SYNC_MSB]};
      end
    end

    // Updating only on falls keeps the bit steady across the downstream rising-edge sample
    if (clk_ev == EDGE_FALL) begin
      dout_d = shift_q[PL];
    end

    // Reads the pre-update register, so a coincident clock rise cannot leak into the latch
    if (latch_ev == EDGE_RISE) begin
      mdi_d = shift_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_sync_q <= '0;
      sel_sync_q  <= '0;
      sel_dly_q   <= 1'b0;
      shift_q     <= '0;
      dout_q      <= 1'b0;
      mdi_q       <= '0;
    end else begin
      data_sync_q <= data_sync_d;
      sel_sync_q  <= sel_sync_d;
      sel_dly_q   <= sel_dly_d;
      shift_q     <= shift_d;
      dout_q      <= dout_d;
      mdi_q       <= mdi_d;
    end
  end

  assign dn.scan_clk      = clk_dly;
  assign dn.scan_select   = sel_dly_q;
  assign dn.scan_latch_en = latch_dly;
  assign dn.scan_data     = dout_q;
  assign module_data_in   = mdi_q;

endmodule
